// File: rtl/div_seq_unit.sv
// Sequential signed divider: restoring division, one quotient bit per cycle.
// Lo receives the quotient (truncated toward zero), Hi the remainder (sign of the dividend).
module div_seq_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [1:0]       o_dbg_state
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_SIGN = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_next;

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_div;
    logic [WIDTH:0]   r_rem;
    logic [CW-1:0]    r_cnt;
    logic             r_neg_q;
    logic             r_neg_r;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_div_zero;

    logic             w_b_zero;
    logic             w_start_ok;
    logic             w_start_zero;
    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;
    logic [WIDTH+1:0] w_rem_sh;
    logic             w_ge;
    logic [WIDTH:0]   w_diff;

    assign w_b_zero     = (b == '0);
    assign w_start_ok   = (r_state == S_IDLE) && start && !w_b_zero;
    assign w_start_zero = (r_state == S_IDLE) && start && w_b_zero;

    // Magnitudes wrap in unsigned arithmetic, so the most negative value maps to itself.
    assign w_abs_a = a[WIDTH-1] ? -a : a;
    assign w_abs_b = b[WIDTH-1] ? -b : b;

    assign w_rem_sh = {r_rem, r_q[WIDTH-1]};
    assign w_ge     = (w_rem_sh >= {2'b00, r_div});
    assign w_diff   = w_rem_sh[WIDTH:0] - {1'b0, r_div};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_start_ok) w_next = S_RUN;
            S_RUN:  if (r_cnt == LAST_ITER) w_next = S_SIGN;
            S_SIGN: w_next = S_DONE;
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_q        <= '0;
            r_div      <= '0;
            r_rem      <= '0;
            r_cnt      <= '0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_div_zero <= 1'b0;
        end else begin
            r_div_zero <= w_start_zero;
            case (r_state)
                S_IDLE: begin
                    if (w_start_ok) begin
                        r_q     <= w_abs_a;
                        r_div   <= w_abs_b;
                        r_rem   <= '0;
                        r_cnt   <= '0;
                        r_neg_q <= a[WIDTH-1] ^ b[WIDTH-1];
                        r_neg_r <= a[WIDTH-1];
                    end
                end
                S_RUN: begin
                    // Restore by simply keeping the shifted remainder when the trial would go negative.
                    r_rem <= w_ge ? w_diff : w_rem_sh[WIDTH:0];
                    r_q   <= {r_q[WIDTH-2:0], w_ge};
                    r_cnt <= r_cnt + 1'b1;
                end
                S_SIGN: begin
                    r_lo <= r_neg_q ? -r_q : r_q;
                    r_hi <= r_neg_r ? -r_rem[WIDTH-1:0] : r_rem[WIDTH-1:0];
                end
                default: ;
            endcase
        end
    end

    assign hi_out      = r_hi;
    assign lo_out      = r_lo;
    assign busy        = (r_state != S_IDLE);
    assign done        = (r_state == S_DONE);
    assign div_zero    = r_div_zero;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_div_seq_unit.sv
// Directed bench for div_seq_unit: latency, signed results, divide-by-zero,
// busy-time start rejection and asynchronous reset mid-operation.
module tb_div_seq_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi_out;
    logic [31:0] lo_out;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [1:0]  dbg_state;

    int total = 0;
    int bad   = 0;

    div_seq_unit #(.WIDTH(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .a           (a),
        .b           (b),
        .hi_out      (hi_out),
        .lo_out      (lo_out),
        .busy        (busy),
        .done        (done),
        .div_zero    (div_zero),
        .o_dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Steps one edge at a time until done is seen or the budget runs out.
    task automatic wait_done(output int n, output logic seen_dz);
        n = 0;
        seen_dz = 1'b0;
        while (done !== 1'b1 && n < 60) begin
            @(posedge clk);
            #1;
            n++;
            if (div_zero === 1'b1) seen_dz = 1'b1;
        end
    endtask

    // Issues a request, expects done in the cycle after the 33rd edge past the sampling edge.
    task automatic run_div(input string tag, input logic [31:0] ta, input logic [31:0] tb,
                           input logic [31:0] elo, input logic [31:0] ehi);
        int   n;
        logic dz;
        a = ta;
        b = tb;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk({tag, "_busy"}, {31'b0, busy}, 32'd1);
        wait_done(n, dz);
        chk({tag, "_lat"}, n, 32'd33);
        chk({tag, "_lo"}, lo_out, elo);
        chk({tag, "_hi"}, hi_out, ehi);
        chk({tag, "_nodz"}, {31'b0, dz}, 32'd0);
        @(posedge clk);
        #1;
        chk({tag, "_donefall"}, {31'b0, done}, 32'd0);
    endtask

    initial begin
        int   n;
        logic dz;

        reset = 1'b0;
        start = 1'b0;
        a = '0;
        b = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_lo", lo_out, 32'd0);
        chk("rst_hi", hi_out, 32'd0);
        chk("rst_flags", {29'b0, busy, done, div_zero}, 32'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        run_div("d7_2",    32'd7,          32'd2,          32'h00000003, 32'h00000001);
        run_div("dm7_2",   32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD, 32'hFFFFFFFF);
        run_div("d7_m2",   32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD, 32'h00000001);
        run_div("dmin_m1", 32'h80000000,   32'hFFFFFFFF,   32'h80000000, 32'h00000000);
        run_div("d100_7",  32'd100,        32'd7,          32'd14,       32'd2);

        // Divide by zero: flag for one cycle, nothing else moves.
        a = 32'd5;
        b = 32'd0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("dz_flag", {31'b0, div_zero}, 32'd1);
        chk("dz_busy", {31'b0, busy}, 32'd0);
        chk("dz_done", {31'b0, done}, 32'd0);
        chk("dz_lo", lo_out, 32'd14);
        chk("dz_hi", hi_out, 32'd2);
        @(posedge clk);
        #1;
        chk("dz_fall", {31'b0, div_zero}, 32'd0);
        chk("dz_idle", {31'b0, busy}, 32'd0);

        // A start while busy must not disturb the running operation.
        a = 32'd100;
        b = 32'd7;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        a = 32'd1;
        b = 32'd1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(n, dz);
        chk("ign_lat", n + 10, 32'd33);
        chk("ign_lo", lo_out, 32'd14);
        chk("ign_hi", hi_out, 32'd2);

        // Start held during the done cycle is ignored; the next edge (idle) accepts it.
        a = 32'd9;
        b = 32'd3;
        start = 1'b1;
        @(posedge clk);
        #1;
        chk("b2b_reject", {31'b0, busy}, 32'd0);
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("b2b_accept", {31'b0, busy}, 32'd1);
        wait_done(n, dz);
        chk("b2b_lat", n, 32'd33);
        chk("b2b_lo", lo_out, 32'd3);
        chk("b2b_hi", hi_out, 32'd0);
        @(posedge clk);
        #1;

        // Asynchronous reset in the middle of RUN.
        a = 32'd100;
        b = 32'd7;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (14) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_lo", lo_out, 32'd0);
        chk("arst_hi", hi_out, 32'd0);
        chk("arst_flags", {29'b0, busy, done, div_zero}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        dz = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1 || busy === 1'b1) dz = 1'b1;
        end
        chk("arst_quiet", {31'b0, dz}, 32'd0);

        run_div("d9_3", 32'd9, 32'd3, 32'd3, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
